pov_char_sequencer: RTL

Sequences the character latch of the POV display once per revolution. Holds a 16-entry, 7-bit ASCII message buffer written by the host. On each revolution Sync it issues one LoadChar/Ascii pair per message character, then steps a per-character column index on each ColTick. It sits between the rotation-sense/column-timing logic and the character latch plus font ROM.

---
 rtl/pov_char_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pov_char_sequencer.sv
// ============================================================================
// pov_char_sequencer: per-revolution character sequencer for the POV display.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pov_char_sequencer #(
  parameter int MSG_DEPTH     = 16,
  parameter int ADDR_W        = 4,
  parameter int COLS_PER_CHAR = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [6:0]        wr_data,
  input  logic [ADDR_W:0]   msg_len,
  input  logic              sync,
  input  logic              col_tick,
  output logic              load_char,
  output logic [6:0]        ascii,
  output logic [2:0]        column,
  output logic              blank,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DRAW = 2'd2
  } state_t;

  localparam logic [2:0]      C_LAST_COL = 3'(COLS_PER_CHAR - 1);
  localparam logic [ADDR_W:0] C_DEPTH    = (ADDR_W + 1)'(MSG_DEPTH);

  logic [6:0]        r_mem [MSG_DEPTH];
  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W:0]   r_len;

  logic [ADDR_W:0]   w_len_clamped;
  logic [ADDR_W-1:0] w_idx_inc;
  logic              w_more;
  logic [2:0]        w_col_inc;
  logic [6:0]        w_rd_first;
  logic [6:0]        w_rd_next;

  assign w_len_clamped = (msg_len > C_DEPTH) ? C_DEPTH : msg_len;
  assign w_idx_inc     = r_idx + ADDR_W'(1);
  assign w_more        = ({1'b0, r_idx} + (ADDR_W + 1)'(1)) < r_len;
  assign w_col_inc     = column + 3'd1;
  // The character is fetched on the edge that enters LOAD, so a same-cycle
  // write to that address is seen only by the following frame.
  assign w_rd_first    = r_mem[0];
  assign w_rd_next     = r_mem[w_idx_inc];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_len     <= '0;
      load_char <= 1'b0;
      ascii     <= '0;
      column    <= '0;
      blank     <= 1'b1;
      busy      <= 1'b0;
    end else begin
      load_char <= 1'b0;
      if (sync) begin
        // Sync restarts from any state and swallows a coincident col_tick.
        r_len  <= w_len_clamped;
        r_idx  <= '0;
        column <= '0;
        if (w_len_clamped == '0) begin
          r_state <= S_IDLE;
          blank   <= 1'b1;
          busy    <= 1'b0;
        end else begin
          r_state   <= S_LOAD;
          load_char <= 1'b1;
          ascii     <= w_rd_first;
          blank     <= 1'b0;
          busy      <= 1'b1;
        end
      end else begin
        case (r_state)
          S_LOAD: begin
            r_state <= S_DRAW;
            column  <= '0;
          end
          S_DRAW: begin
            if (col_tick) begin
              if (column != C_LAST_COL) begin
                column <= w_col_inc;
                blank  <= (w_col_inc == C_LAST_COL);
              end else if (w_more) begin
                r_idx     <= w_idx_inc;
                r_state   <= S_LOAD;
                load_char <= 1'b1;
                ascii     <= w_rd_next;
                column    <= '0;
                blank     <= 1'b0;
              end else begin
                r_state <= S_IDLE;
                column  <= '0;
                blank   <= 1'b1;
                busy    <= 1'b0;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
